// File: rtl/random_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : random_request_arbiter
// Description : Shares one free-running 8-bit random source among NUM_REQ
//               requesters. Grants are issued round-robin. Each grant samples
//               the source once and reduces the sample modulo the requester's
//               bound by repeated subtraction. The result is returned with a
//               one-cycle, one-hot acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module random_request_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             rand_value,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   range,
  output logic [NUM_REQ-1:0]     ack,
  output logic [7:0]             data_out,
  output logic                   busy
);

  // Requester index width, plus one spare bit so that ptr + offset cannot
  // overflow before the wrap correction is applied.
  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam int               CAND_W   = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REDUCE = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  // State and datapath registers
  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [IDX_W-1:0]   sel_q,   sel_d;
  logic [7:0]         work_q,  work_d;
  logic [7:0]         bound_q, bound_d;
  logic [NUM_REQ-1:0] ack_q,   ack_d;
  logic [7:0]         data_q,  data_d;

  // Arbitration results
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [CAND_W-1:0]  cand_w;
  logic [IDX_W-1:0]   cand_idx;

  // Per-requester bounds unpacked for indexed lookup
  logic [7:0]         range_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_range_slice
      assign range_arr[gi] = range[8*gi +: 8];
    end
  endgenerate

  // Round-robin scan: first set req bit starting at ptr, wrapping at NUM_REQ
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_w = {1'b0, ptr_q} + CAND_W'(k);
      if (cand_w >= CAND_W'(NUM_REQ)) begin
        cand_w = cand_w - CAND_W'(NUM_REQ);
      end
      cand_idx = cand_w[IDX_W-1:0];
      if (!grant_valid && req[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: grant in IDLE, subtract in REDUCE, strobe in ACK
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    work_d  = work_q;
    bound_d = bound_q;
    ack_d   = '0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          // The random sample and the bound are captured only here;
          // later changes on either input do not affect this service.
          sel_d   = grant_idx;
          work_d  = rand_value;
          bound_d = range_arr[grant_idx];
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        // A zero bound means full range: skip reduction entirely.
        if ((bound_q != 8'd0) && (work_q >= bound_q)) begin
          work_d = work_q - bound_q;
        end else begin
          ack_d[sel_q] = 1'b1;
          data_d       = work_q;
          ptr_d        = (sel_q == LAST_IDX) ? '0 : (sel_q + IDX_W'(1));
          state_d      = S_ACK;
        end
      end
      S_ACK: begin
        // No arbitration in this cycle, so the minimum period is 3 cycles.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register update with asynchronous reset discarding any pending service
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      work_q  <= 8'd0;
      bound_q <= 8'd0;
      ack_q   <= '0;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      work_q  <= work_d;
      bound_q <= bound_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  assign ack      = ack_q;
  assign data_out = data_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_random_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_random_request_arbiter
// Description : Directed self-checking bench for random_request_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_random_request_arbiter;

  logic        clock;
  logic        reset;
  logic [7:0]  rand_value;
  logic [3:0]  req;
  logic [31:0] range_in;
  logic [3:0]  ack;
  logic [7:0]  data_out;
  logic        busy;

  int checks;
  int errors;
  int acks_seen;

  random_request_arbiter #(.NUM_REQ(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .rand_value (rand_value),
    .req        (req),
    .range      (range_in),
    .ack        (ack),
    .data_out   (data_out),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for an ack (bounded), measuring edges from the request cycle.
  // After the grant edge the random input and the bounds are scrambled,
  // which must not influence the result.
  task automatic service(input string tag, input int grant_edge,
                         input logic [3:0] exp_ack, input logic [7:0] exp_data,
                         input int exp_lat);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      tick();
      n++;
      if (n == grant_edge) begin
        check({tag, "_busy_grant"}, 32'(busy), 32'd1);
        rand_value = 8'h5A;
        range_in   = {4{8'h03}};
      end
      if (ack != 4'b0000) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_ack"},     32'(ack), 32'(exp_ack));
    check({tag, "_data"},    32'(data_out), 32'(exp_data));
    check({tag, "_busy_ack"}, 32'(busy), 32'd1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    acks_seen  = 0;
    clock      = 1'b0;
    reset      = 1'b1;
    req        = 4'b0000;
    range_in   = '0;
    rand_value = 8'h00;

    // Reset values visible before any clock edge
    #1;
    check("rst_ack",  32'(ack), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Round-robin: all requesting, each drops after its ack
    req        = 4'b1111;
    range_in   = '0;
    rand_value = 8'h10;
    service("rr0", 1, 4'b0001, 8'h10, 2);
    for (int i = 1; i < 4; i++) begin
      req[i-1]   = 1'b0;
      range_in   = '0;
      rand_value = 8'(8'h10 + i);
      service("rr", 2, 4'(1 << i), 8'(8'h10 + i), 3);
    end

    // Pointer wrapped to 0: 1001 grants requester 0 then 3
    req        = 4'b1001;
    range_in   = '0;
    rand_value = 8'h21;
    service("wrap0", 2, 4'b0001, 8'h21, 3);
    req        = 4'b1000;
    range_in   = '0;
    rand_value = 8'h22;
    service("wrap3", 2, 4'b1000, 8'h22, 3);
    req = 4'b0000;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ack",  32'(ack), 32'd0);
    check("idle_hold", 32'(data_out), 32'h22);

    // Single full-range request
    req        = 4'b0001;
    range_in   = '0;
    rand_value = 8'hA7;
    service("full", 1, 4'b0001, 8'hA7, 2);
    req = 4'b0000;
    tick();
    check("full_busy_after", 32'(busy), 32'd0);
    check("full_hold",       32'(data_out), 32'hA7);

    // Worst case: bound 1, sample 255
    req             = 4'b0100;
    range_in        = '0;
    range_in[23:16] = 8'd1;
    rand_value      = 8'hFF;
    service("worst", 1, 4'b0100, 8'h00, 257);
    req = 4'b0000;
    tick();

    // Bound 255, sample 255: one subtraction
    req             = 4'b0100;
    range_in        = '0;
    range_in[23:16] = 8'd255;
    rand_value      = 8'hFF;
    service("b255", 1, 4'b0100, 8'h00, 3);
    req = 4'b0000;
    tick();

    // Modulo 10 of 100: ten subtractions
    req            = 4'b0010;
    range_in       = '0;
    range_in[15:8] = 8'd10;
    rand_value     = 8'd100;
    service("mod100", 1, 4'b0010, 8'd0, 12);
    req = 4'b0000;
    tick();

    // Modulo 10 of 47: four subtractions, remainder 7
    req            = 4'b0010;
    range_in       = '0;
    range_in[15:8] = 8'd10;
    rand_value     = 8'd47;
    service("mod47", 1, 4'b0010, 8'd7, 6);
    req = 4'b0000;
    tick();

    // Reset in the middle of a long reduction
    req           = 4'b0001;
    range_in      = '0;
    range_in[7:0] = 8'd1;
    rand_value    = 8'd200;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 0) rand_value = 8'h5A;
      if (ack != 4'b0000) acks_seen++;
    end
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack",  32'(ack), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    req        = 4'b1000;
    range_in   = '0;
    rand_value = 8'h3C;
    tick();
    if (ack != 4'b0000) acks_seen++;
    check("mid_no_ack", 32'(acks_seen), 32'd0);
    reset = 1'b0;
    service("post_rst", 1, 4'b1000, 8'h3C, 2);
    req = 4'b0000;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/random_request_arbiter.md
# random_request_arbiter

Shares the free-running 8-bit pseudo-random source among NUM_REQ game-logic requesters, such as enemy spawners, sprite colour pickers and maze generators. Each requester raises a request and supplies an upper bound. The block arbitrates round-robin and samples the random source once per grant. It reduces the sample modulo the bound by sequential subtraction, then returns the result with a one-cycle acknowledge. It sits between the randomizer and game-state FSMs, on the same clock as both.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..8.
- clock  in  1: system clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- rand_value  in  8: random sample, registered upstream by the randomizer on clock.
- req  in  NUM_REQ: per-requester request level.
- range  in  8*NUM_REQ: per-requester bound; requester i uses bits [8i+7:8i]. 0 means full range 0..255.
- ack  out  NUM_REQ: one-hot, one-cycle result strobe.
- data_out  out  8: reduced random result; valid while ack is high, held until the next ack.
- busy  out  1: high while a request is being serviced (REDUCE or ACK).

## Operation
- Reset values:
  - ack = 0, data_out = 0x00, busy = 0.
  - State IDLE, round-robin pointer ptr = 0.
  - Internal work, bound and sel registers = 0.
- States: IDLE, REDUCE, ACK.
- IDLE, no req bit high: remain in IDLE.
- IDLE, any req bit high:
  - Select the first set bit scanning ptr, ptr+1, … with wrap at NUM_REQ.
  - Latch: sel = winner, work = rand_value, bound = range slice of winner.
  - Go to REDUCE.
- REDUCE, bound != 0 and work >= bound: work = work - bound; stay in REDUCE.
- REDUCE, otherwise:
  - Assert ack[sel] and load data_out = work, both registered.
  - ptr = (sel + 1) mod NUM_REQ.
  - Go to ACK.
- ACK: lasts exactly one cycle; ack[sel] high; no arbitration this cycle; then return to IDLE, ack = 0.
- Result rule: data_out = rand_value mod bound for bound ≠ 0, else the raw sample. The result is always in [0, bound-1].
- Arithmetic: 8-bit unsigned; the subtraction never underflows, because it is guarded by work >= bound.
- Requester protocol:
  - Hold req high until ack is seen.
  - Drop req in the cycle after ack.
  - A req still high in IDLE after ACK is a new request.
- Request dropped during REDUCE: the operation still completes and ack still pulses. Range changes after the grant are ignored.
- Simultaneous requests: exactly one grant per service; the others wait. Round-robin guarantees each waiting requester is served within NUM_REQ services.
- Reset mid-operation (any state): outputs return to reset values immediately. The pending service is discarded with no ack. After release, arbitration restarts from ptr = 0.

## Timing
- Request seen in IDLE at cycle t: REDUCE occupies cycles t+1 … t+1+n, where n = floor(sample / bound) subtractions (n = 0 if bound = 0 or sample < bound).
- ack is high in cycle t+2+n. Minimum request-to-ack latency is 2 cycles; maximum is 257 cycles (bound = 1, sample = 255).
- busy is high from t+1 through t+2+n inclusive.
- Back-to-back throughput: the next grant is decided in the IDLE cycle t+3+n at the earliest, so the minimum service period is 3 cycles.
- rand_value is sampled only at the grant edge; its value in other cycles has no effect.

## Test plan
- Reset: assert reset asynchronously between clock edges -> ack = 0, data_out = 0x00 and busy = 0 with no clock edge required; after release the first grant goes to requester 0 when all req bits are high.
- Single full-range request: req = 4'b0001, range0 = 0, rand_value = 0xA7 at the grant edge -> ack = 4'b0001 at t+2, data_out = 0xA7, busy high for cycles t+1..t+2.
- Modulo reduction: req[1] high, range1 = 10, rand_value = 100 -> 10 REDUCE subtractions, ack[1] at t+12, data_out = 0; repeat with rand_value = 0x2F (47) -> ack at t+6, data_out = 7.
- Round-robin fairness: req = 4'b1111 held, each requester dropping req after its ack, all ranges 0 -> acks in order 0, 1, 2, 3, each one-hot, 3 cycles apart. Then req = 4'b1001 -> grant to 0, since ptr wrapped to 0.
- Worst-case latency: range2 = 1, rand_value = 255 -> ack[2] at t+257, data_out = 0; range2 = 255 with rand_value = 255 -> data_out = 0 after 1 subtraction.
- Reset mid-REDUCE: range0 = 1, rand_value = 200; assert reset at t+50 -> no ack is ever issued for that request, busy = 0 immediately. With req[3] high after release -> requester 3 is granted, ack[3] only.
